// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator: decodes the immediate format, extends to XLEN,
// and presents the result through a registered valid/ready stage with one skid entry.
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter bit          USE_OP = 1'b0,
  parameter int unsigned TAG_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_Z = 3'd5;
  localparam logic [2:0] FMT_N = 3'd6;
  localparam logic [2:0] FMT_X = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [2:0]  dec_fmt;
  logic [31:0] imm32;
  entry_t      dec_entry;

  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
  logic   rdy_q, rdy_d;
  logic   in_fire, out_fire;

  // Format resolution and 32-bit immediate assembly, then sign extension to XLEN.
  always_comb begin : decode
    dec_fmt = FMT_X;
    imm32   = 32'd0;
    if (USE_OP) begin
      dec_fmt = op_i;
    end else begin
      case (instr_i[6:0])
        7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: dec_fmt = FMT_I;
        7'b0011011: dec_fmt = IS_RV64 ? FMT_I : FMT_X;
        7'b0100011: dec_fmt = FMT_S;
        7'b1100011: dec_fmt = FMT_B;
        7'b0110111, 7'b0010111: dec_fmt = FMT_U;
        7'b1101111: dec_fmt = FMT_J;
        7'b0110011: dec_fmt = FMT_N;
        7'b0111011: dec_fmt = IS_RV64 ? FMT_N : FMT_X;
        7'b1110011: dec_fmt = instr_i[14] ? FMT_Z : FMT_I;
        default:    dec_fmt = FMT_X;
      endcase
    end
    case (dec_fmt)
      FMT_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      FMT_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      FMT_B:   imm32 = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      FMT_U:   imm32 = {instr_i[31:12], 12'd0};
      FMT_J:   imm32 = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      FMT_Z:   imm32 = {27'd0, instr_i[19:15]};
      default: imm32 = 32'd0;
    endcase
    dec_entry.imm     = XLEN'($signed(imm32));
    dec_entry.fmt     = dec_fmt;
    dec_entry.illegal = (dec_fmt == FMT_X);
    dec_entry.tag     = tag_i;
  end

  assign in_fire  = in_valid_i && rdy_q;
  assign out_fire = main_vld_q && out_ready_i;

  // Main/skid next state; ready depends only on next skid occupancy.
  always_comb begin : next_state
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush_i) begin
      main_d     = '0;
      main_vld_d = 1'b0;
      skid_d     = '0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d     = dec_entry;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d     = dec_entry;
      skid_vld_d = 1'b1;
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin : regs
    if (rst) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready_o  = rdy_q;
  assign out_valid_o = main_vld_q;
  assign imm_o       = main_q.imm;
  assign fmt_o       = main_q.fmt;
  assign illegal_o   = main_q.illegal;
  assign tag_o       = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: three instances (RV32 opcode decode, RV64 opcode
// decode, RV32 external op select) share stimulus wires but have separate valids.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  op;
  logic [31:0] tag;
  logic [2:0]  vld;

  wire [2:0]  rdy, ovld, ill;
  wire [31:0] imm0, imm2;
  wire [63:0] imm1;
  wire [2:0]  fmt0, fmt1, fmt2;
  wire [31:0] tag0, tag1, tag2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t em;

  int checks = 0;
  int errors = 0;
  logic [31:0] tag_ctr = 32'h100;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .USE_OP(1'b0), .TAG_W(32)) u_rv32 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(vld[0]), .in_ready_o(rdy[0]),
    .instr_i(instr), .op_i(op), .tag_i(tag), .out_valid_o(ovld[0]), .out_ready_i(out_ready),
    .imm_o(imm0), .fmt_o(fmt0), .illegal_o(ill[0]), .tag_o(tag0));

  imm_gen_pipe #(.XLEN(64), .USE_OP(1'b0), .TAG_W(32)) u_rv64 (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(vld[1]), .in_ready_o(rdy[1]),
    .instr_i(instr), .op_i(op), .tag_i(tag), .out_valid_o(ovld[1]), .out_ready_i(out_ready),
    .imm_o(imm1), .fmt_o(fmt1), .illegal_o(ill[1]), .tag_o(tag1));

  imm_gen_pipe #(.XLEN(32), .USE_OP(1'b1), .TAG_W(32)) u_op (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(vld[2]), .in_ready_o(rdy[2]),
    .instr_i(instr), .op_i(op), .tag_i(tag), .out_valid_o(ovld[2]), .out_ready_i(out_ready),
    .imm_o(imm2), .fmt_o(fmt2), .illegal_o(ill[2]), .tag_o(tag2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp(input int d, input logic [63:0] imm, input logic [2:0] fmt,
                     input logic il, input logic [31:0] tg, input exp_t e);
    chk($sformatf("d%0d.imm tag=%h", d, e.tag), imm, e.imm);
    chk($sformatf("d%0d.fmt tag=%h", d, e.tag), 64'(fmt), 64'(e.fmt));
    chk($sformatf("d%0d.ill tag=%h", d, e.tag), 64'(il), 64'(e.ill));
    chk($sformatf("d%0d.tag", d), 64'(tg), 64'(e.tag));
  endtask

  task automatic unexpected(input int d);
    checks++;
    errors++;
    $display("FAIL d%0d.unexpected_output: got out_valid=1 expected no pending result", d);
  endtask

  // Monitor: every output transfer pops and compares the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      if (ovld[0]) begin
        if (q0.size() == 0) unexpected(0);
        else begin em = q0.pop_front(); cmp(0, {32'd0, imm0}, fmt0, ill[0], tag0, em); end
      end
      if (ovld[1]) begin
        if (q1.size() == 0) unexpected(1);
        else begin em = q1.pop_front(); cmp(1, imm1, fmt1, ill[1], tag1, em); end
      end
      if (ovld[2]) begin
        if (q2.size() == 0) unexpected(2);
        else begin em = q2.pop_front(); cmp(2, {32'd0, imm2}, fmt2, ill[2], tag2, em); end
      end
    end
  end

  // Offer one word to instance d; push its expected result once it is accepted.
  task automatic send(input int d, input logic [31:0] ins, input logic [2:0] o,
                      input logic [63:0] eimm, input logic [2:0] efmt, input logic eill);
    logic acc;
    logic r;
    exp_t e;
    acc = 1'b0;
    instr = ins;
    op = o;
    tag = tag_ctr;
    vld[d] = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      r = rdy[d];
      @(posedge clk);
      if (r) acc = 1'b1;
    end
    if (acc) begin
      e.imm = eimm; e.fmt = efmt; e.ill = eill; e.tag = tag_ctr;
      case (d)
        0: q0.push_back(e);
        1: q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end else begin
      checks++;
      errors++;
      $display("FAIL d%0d.accept_timeout: got in_ready=0 for 50 cycles expected acceptance", d);
    end
    #1;
    vld[d] = 1'b0;
    tag_ctr = tag_ctr + 32'd1;
  endtask

  task automatic chk_all_idle(input string name);
    chk({name, ".out_valid"}, 64'(ovld), 64'd0);
    chk({name, ".in_ready"}, 64'(rdy), 64'd7);
    chk({name, ".imm0"}, 64'(imm0), 64'd0);
    chk({name, ".imm1"}, imm1, 64'd0);
    chk({name, ".imm2"}, 64'(imm2), 64'd0);
    chk({name, ".fmt"}, 64'({fmt0, fmt1, fmt2}), 64'd0);
    chk({name, ".ill"}, 64'(ill), 64'd0);
    chk({name, ".tag"}, 64'(tag0 | tag1 | tag2), 64'd0);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    instr = 32'd0; op = 3'd0; tag = 32'd0; vld = 3'd0;
    #3;
    chk_all_idle("reset");
    @(negedge clk);
    rst = 1'b0;
    step(1);

    // RV32 opcode decode; first word checks one-cycle latency.
    send(0, 32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 1'b0);
    chk("latency.out_valid", 64'(ovld[0]), 64'd1);
    chk("latency.imm", 64'(imm0), 64'hFFFFFFFF);
    send(0, 32'hFE112E23, 3'd0, 64'hFFFFFFFC, 3'd1, 1'b0);
    send(0, 32'h800000EF, 3'd0, 64'hFFF00000, 3'd4, 1'b0);
    send(0, 32'h000FD073, 3'd0, 64'h0000001F, 3'd5, 1'b0);
    send(0, 32'h12301073, 3'd0, 64'h00000123, 3'd0, 1'b0);
    send(0, 32'h80000F63, 3'd0, 64'hFFFFF01E, 3'd2, 1'b0);
    send(0, 32'h800002B7, 3'd0, 64'h80000000, 3'd3, 1'b0);
    send(0, 32'h00B50533, 3'd0, 64'h0, 3'd6, 1'b0);
    send(0, 32'h0000001B, 3'd0, 64'h0, 3'd7, 1'b1);
    send(0, 32'h0000003B, 3'd0, 64'h0, 3'd7, 1'b1);
    send(0, 32'hFFF0007F, 3'd0, 64'h0, 3'd7, 1'b1);

    // RV64 opcode decode.
    send(1, 32'h800002B7, 3'd0, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
    send(1, 32'h0000003B, 3'd0, 64'h0, 3'd6, 1'b0);
    send(1, 32'hFFF0009B, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0, 1'b0);
    send(1, 32'h00001297, 3'd0, 64'h0000000000001000, 3'd3, 1'b0);
    send(1, 32'h800000EF, 3'd0, 64'hFFFFFFFFFFF00000, 3'd4, 1'b0);

    // External op select; opcode field ignored.
    send(2, 32'h80000F63, 3'd2, 64'hFFFFF01E, 3'd2, 1'b0);
    send(2, 32'hFFF00093, 3'd7, 64'h0, 3'd7, 1'b1);
    send(2, 32'h000FD073, 3'd5, 64'h0000001F, 3'd5, 1'b0);
    send(2, 32'h7FF0007F, 3'd0, 64'h000007FF, 3'd0, 1'b0);
    send(2, 32'hFFF00093, 3'd6, 64'h0, 3'd6, 1'b0);
    step(3);
    chk("drain.q_empty", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    // Backpressure: two words fill main+skid, third waits until drain starts.
    out_ready = 1'b0;
    send(0, 32'h00100093, 3'd0, 64'd1, 3'd0, 1'b0);
    send(0, 32'h00200093, 3'd0, 64'd2, 3'd0, 1'b0);
    chk("bp.in_ready_low", 64'(rdy[0]), 64'd0);
    chk("bp.out_valid", 64'(ovld[0]), 64'd1);
    chk("bp.hold_imm", 64'(imm0), 64'd1);
    step(2);
    chk("bp.stable_imm", 64'(imm0), 64'd1);
    chk("bp.still_not_ready", 64'(rdy[0]), 64'd0);
    fork
      begin
        step(2);
        out_ready = 1'b1;
      end
    join_none
    send(0, 32'h00300093, 3'd0, 64'd3, 3'd0, 1'b0);
    step(4);
    chk("bp.q_empty", 64'(q0.size()), 64'd0);
    chk("bp.ready_back", 64'(rdy[0]), 64'd1);

    // Flush with main and skid full while a new word is offered.
    out_ready = 1'b0;
    send(0, 32'h00500093, 3'd0, 64'd5, 3'd0, 1'b0);
    send(0, 32'h00600093, 3'd0, 64'd6, 3'd0, 1'b0);
    instr = 32'h00700093; tag = 32'hDEAD; vld[0] = 1'b1; flush = 1'b1;
    step(1);
    flush = 1'b0; vld[0] = 1'b0;
    q0.delete();
    chk("flush.out_valid", 64'(ovld[0]), 64'd0);
    chk("flush.in_ready", 64'(rdy[0]), 64'd1);
    chk("flush.imm", 64'(imm0), 64'd0);
    chk("flush.fmt_ill_tag", 64'({fmt0, ill[0], tag0}), 64'd0);
    // Flush also drops an input that would otherwise be accepted.
    instr = 32'h00800093; tag = 32'hBEEF; vld[0] = 1'b1; flush = 1'b1;
    step(1);
    flush = 1'b0; vld[0] = 1'b0;
    chk("flush2.out_valid", 64'(ovld[0]), 64'd0);
    out_ready = 1'b1;
    step(3);
    chk("flush2.no_output", 64'(ovld[0]), 64'd0);

    // Async reset with results held in every instance.
    out_ready = 1'b0;
    send(0, 32'hFFF00093, 3'd0, 64'hFFFFFFFF, 3'd0, 1'b0);
    send(1, 32'h800002B7, 3'd0, 64'hFFFFFFFF80000000, 3'd3, 1'b0);
    send(2, 32'h80000F63, 3'd2, 64'hFFFFF01E, 3'd2, 1'b0);
    chk("prereset.out_valid", 64'(ovld), 64'd7);
    #2;
    rst = 1'b1;
    #1;
    chk_all_idle("async_reset");
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    step(3);
    chk("postreset.no_output", 64'(ovld), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
